load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request per transaction from the RV32 execute stage and drives the byte-addressed, big-endian DynamicMemory port.
- Memory port: WE, funct3, ADDRESS, WRITE_DATA, READ_DATA; read asynchronous, write synchronous; memory implements only sb and sw.
- Sequences halfword stores as two sb writes and registers load data.
- Extracts, sign- or zero-extends and returns load results; flags illegal or out-of-range accesses without touching memory.

Parameters:
- ADDR_LIMIT, 1024: highest valid byte address. Any access whose last byte exceeds this is an error.
- CHECK_ALIGN, 1: 1 = misaligned lh/lhu/sh (addr[0]) and lw/sw (addr[1:0]) are errors; 0 = permitted.

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  LSU can accept (high only in IDLE)
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RV32 funct3 (lb0 lh1 lw2 lbu4 lhu5 / sb0 sh1 sw2)
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, right-aligned
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_ERR  out  1  valid with RESP_VALID; 1 = request rejected
- RESP_RDATA  out  32  extended load result; 0 for stores and errors
- MEM_WE  out  1  to memory WE
- MEM_FUNCT3  out  3  to memory funct3 (only 0 or 2 are driven)
- MEM_ADDRESS  out  32  to memory ADDRESS
- MEM_WRITE_DATA  out  32  to memory WRITE_DATA
- MEM_READ_DATA  in  32  from memory READ_DATA (big-endian: [31:24] = byte at ADDRESS)

Behaviour:
- Reset: all outputs 0 except REQ_READY = 1; state IDLE. Takes effect asynchronously, so MEM_WE drops immediately.
- Reset mid-sh: the first byte may already be written; no rollback.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On REQ_VALID && REQ_READY, latch the request.
  - Error check (combinational on REQ_* in IDLE): illegal funct3 (load 3/6/7, store 3..7), range violation (addr + size - 1 > ADDR_LIMIT, computed in 33 bits so wrap counts as error), or misalignment when CHECK_ALIGN = 1.
  - If error -> RESP with ERR = 1; no MEM_WE asserted. Otherwise -> ACCESS with byte counter = 0.
- ACCESS:
  - Memory outputs are driven from registers/state, stable for the whole cycle.
  - sb: MEM_WE = 1, FUNCT3 = 0, ADDRESS = addr, WRITE_DATA[7:0] = wdata[7:0]; 1 cycle.
  - sw: MEM_WE = 1, FUNCT3 = 2, ADDRESS = addr, WRITE_DATA = wdata; 1 cycle.
  - sh: cycle 0 writes addr with wdata[15:8]; cycle 1 writes addr+1 with wdata[7:0], each as FUNCT3 = 0. Counter selects the cycle; 2 cycles total.
  - load: MEM_WE = 0, ADDRESS = addr; MEM_READ_DATA captured at the cycle end; 1 cycle.
  - After the last cycle -> RESP.
- RESP:
  - RESP_VALID = 1 for exactly one cycle, then IDLE.
  - Load extraction from the captured word: lb = sext[31:24], lbu = zext[31:24], lh = sext[31:16], lhu = zext[31:16], lw = [31:0].
- Outside ACCESS: MEM_WE = 0, MEM_FUNCT3 = 0, MEM_ADDRESS = 0, MEM_WRITE_DATA = 0.
- Latency from accept to RESP_VALID: 2 cycles (lb/lh/lw/sb/sw), 3 cycles (sh), 1 cycle (error).
- Back-to-back throughput: one request per latency + 1 cycles; REQ_READY is low in ACCESS and RESP. A REQ_VALID held during busy cycles is ignored until IDLE.
- Request fields may change after acceptance; only latched values are used.

Decomposition:
- Shared package rv32_mem_pkg: funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW), state enum, helper function access_size(funct3).
- One natural sub-module, load_extend: purely combinational; captured word + funct3 -> RESP_RDATA.
- FSM and memory drive stay in the top.

Test Plan:
- Reset: assert RST mid-ACCESS of sh to 0x10 -> MEM_WE falls immediately, REQ_READY = 1, RESP_VALID never pulses; byte 0x10 may hold the high byte.
- sw 0x0000_0020 data 0xDEADBEEF, then lw 0x20 -> memory bytes 20..23 = DE AD BE EF; lw RESP_RDATA = 0xDEADBEEF, RESP_VALID 2 cycles after accept.
- sh 0x22 data 0x0000_1234 -> two MEM_WE cycles (0x22 <- 0x12, 0x23 <- 0x34), RESP_VALID on cycle 3. Then lh 0x22 -> 0x00001234; lb 0x20 with byte 0x80 -> 0xFFFFFF80; lbu -> 0x00000080.
- Errors (CHECK_ALIGN = 1): lw 0x21 -> RESP_ERR = 1 one cycle after accept, RDATA = 0, MEM_WE never high; sw 0x3FE (ADDR_LIMIT = 1024) -> ERR = 1; funct3 = 3 store -> ERR = 1.
- Back-to-back: REQ_VALID held high with sb, sh, lw queued -> REQ_READY pulses exactly at IDLE; three RESP_VALID pulses in order with correct data, no overlap.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// ============================================================================
// Module : rv32_mem_pkg
// Brief  : Shared RV32 memory-access constants, LSU state type and size helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Bytes touched by an access; the unsigned variants share the low bits.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    access_size = 3'd1;
            2'd1:    access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Extracts and sign/zero-extends a load result from a big-endian word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = 32'd0;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{word_i[31]}}, word_i[31:24]};
            F3_LBU:  rdata_o = {24'd0, word_i[31:24]};
            F3_LH:   rdata_o = {{16{word_i[31]}}, word_i[31:16]};
            F3_LHU:  rdata_o = {16'd0, word_i[31:16]};
            F3_LW:   rdata_o = word_i;
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : RV32 load/store initiator for a big-endian sb/sw-only data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import rv32_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT  = 32'd1024,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_funct3_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    logic [2:0]  w_size;
    logic [32:0] w_last;
    logic        w_f3_illegal;
    logic        w_range_err;
    logic        w_misalign;
    logic        w_req_err;
    logic        w_accept;
    logic [31:0] w_ext;

    // Last byte computed in 33 bits so an address wrap is caught as out of range.
    assign w_size       = access_size(req_funct3_i);
    assign w_last       = {1'b0, req_addr_i} + {30'd0, w_size} - 33'd1;
    assign w_range_err  = (w_last > {1'b0, ADDR_LIMIT});
    assign w_f3_illegal = req_we_i ? (req_funct3_i > 3'd2)
                                   : ((req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11));
    assign w_misalign   = CHECK_ALIGN &&
                          (((req_funct3_i[1:0] == 2'd1) && req_addr_i[0]) ||
                           ((req_funct3_i[1:0] == 2'd2) && (req_addr_i[1:0] != 2'd0)));
    assign w_req_err    = w_f3_illegal || w_range_err || w_misalign;
    assign w_accept     = req_valid_i && (state_q == ST_IDLE);

    load_extend u_load_extend (
        .word_i   (word_q),
        .funct3_i (funct3_q),
        .rdata_o  (w_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= 1'b0;
            word_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    err_d    = w_req_err;
                    cnt_d    = 1'b0;
                    state_d  = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    word_d = mem_read_data_i;
                end
                if (we_q && (funct3_q == F3_SH) && !cnt_q) begin
                    cnt_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o      = (state_q == ST_IDLE);
        resp_valid_o     = (state_q == ST_RESP);
        resp_err_o       = (state_q == ST_RESP) && err_q;
        resp_rdata_o     = ((state_q == ST_RESP) && !err_q && !we_q) ? w_ext : 32'd0;
        mem_we_o         = 1'b0;
        mem_funct3_o     = 3'd0;
        mem_address_o    = 32'd0;
        mem_write_data_o = 32'd0;
        if (state_q == ST_ACCESS) begin
            mem_address_o = addr_q;
            if (we_q) begin
                mem_we_o = 1'b1;
                case (funct3_q)
                    F3_SW: begin
                        mem_funct3_o     = 3'd2;
                        mem_write_data_o = wdata_q;
                    end
                    // Halfword goes out high byte first, matching big-endian order.
                    F3_SH: begin
                        mem_address_o    = addr_q + {31'd0, cnt_q};
                        mem_write_data_o = {24'd0, cnt_q ? wdata_q[7:0] : wdata_q[15:8]};
                    end
                    default: mem_write_data_o = {24'd0, wdata_q[7:0]};
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit with a byte memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  mem [0:2047];
    logic [10:0] ma;

    load_store_unit #(.ADDR_LIMIT(32'd1024), .CHECK_ALIGN(1'b1)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_we_i         (req_we),
        .req_funct3_i     (req_funct3),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .resp_valid_o     (resp_valid),
        .resp_err_o       (resp_err),
        .resp_rdata_o     (resp_rdata),
        .mem_we_o         (mem_we),
        .mem_funct3_o     (mem_funct3),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_wdata),
        .mem_read_data_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte memory: asynchronous read, sb/sw synchronous write.
    assign ma        = mem_address[10:0];
    assign mem_rdata = {mem[ma], mem[ma + 11'd1], mem[ma + 11'd2], mem[ma + 11'd3]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_funct3 == 3'd2) begin
                mem[ma]          <= mem_wdata[31:24];
                mem[ma + 11'd1]  <= mem_wdata[23:16];
                mem[ma + 11'd2]  <= mem_wdata[15:8];
                mem[ma + 11'd3]  <= mem_wdata[7:0];
            end else begin
                mem[ma]          <= mem_wdata[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated request: latency counted in cycles from the accepting edge.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_wes);
        int lat;
        int wes;
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'h0000_0155; req_wdata = ~wdata; req_funct3 = ~f3;
        lat = 0;
        wes = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_we) wes++;
            if (resp_valid) break;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".we_cycles"}, wes, exp_wes);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    logic        b_we    [3];
    logic [2:0]  b_f3    [3];
    logic [31:0] b_addr  [3];
    logic [31:0] b_wdata [3];
    logic [31:0] r_rdata [3];
    logic        r_err   [3];
    int          rdy_at  [3];

    initial begin
        int resp_cnt;
        int idx;
        int nresp;
        int overlap;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;

        @(negedge clk);
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst.mem_address", mem_address, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        // Reset landing in the first sh cycle.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h0000_ABCD;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("shrst.mem_we", {31'd0, mem_we}, 32'd1);
        chk("shrst.addr", mem_address, 32'h10);
        chk("shrst.wdata", mem_wdata, 32'h0000_00AB);
        #1 rst = 1'b1;
        #1;
        chk("shrst.we_drop", {31'd0, mem_we}, 32'd0);
        chk("shrst.ready", {31'd0, req_ready}, 32'd1);
        resp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        chk("shrst.no_resp", resp_cnt, 0);
        chk("shrst.byte11", {24'd0, mem[11'h11]}, 32'h0);

        do_req("sw20", 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1);
        chk("sw20.mem", {mem[11'h20], mem[11'h21], mem[11'h22], mem[11'h23]}, 32'hDEAD_BEEF);
        do_req("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0);
        do_req("sh22", 1'b1, 3'd1, 32'h22, 32'h0000_1234, 3, 1'b0, 32'h0, 2);
        chk("sh22.mem", {16'd0, mem[11'h22], mem[11'h23]}, 32'h0000_1234);
        do_req("lh22", 1'b0, 3'd1, 32'h22, 32'h0, 2, 1'b0, 32'h0000_1234, 0);
        do_req("sb20", 1'b1, 3'd0, 32'h20, 32'h0000_0080, 2, 1'b0, 32'h0, 1);
        do_req("lb20", 1'b0, 3'd0, 32'h20, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 0);
        do_req("lbu20", 1'b0, 3'd4, 32'h20, 32'h0, 2, 1'b0, 32'h0000_0080, 0);
        do_req("lh20", 1'b0, 3'd1, 32'h20, 32'h0, 2, 1'b0, 32'hFFFF_80AD, 0);
        do_req("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, 2, 1'b0, 32'h0000_80AD, 0);
        do_req("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 2, 1'b0, 32'h80AD_1234, 0);

        do_req("lw21", 1'b0, 3'd2, 32'h21, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("sw3fe", 1'b1, 3'd2, 32'h3FE, 32'h1111_2222, 1, 1'b1, 32'h0, 0);
        do_req("st_f3_3", 1'b1, 3'd3, 32'h40, 32'h1, 1, 1'b1, 32'h0, 0);
        do_req("ld_f3_6", 1'b0, 3'd6, 32'h40, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("lh23", 1'b0, 3'd1, 32'h23, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("sb400", 1'b1, 3'd0, 32'h400, 32'h0000_007F, 2, 1'b0, 32'h0, 1);
        do_req("lb400", 1'b0, 3'd0, 32'h400, 32'h0, 2, 1'b0, 32'h0000_007F, 0);
        do_req("lb401", 1'b0, 3'd0, 32'h401, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("lw400", 1'b0, 3'd2, 32'h400, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("lw3fc", 1'b0, 3'd2, 32'h3FC, 32'h0, 2, 1'b0, 32'h0, 0);
        do_req("lw_wrap", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 1, 1'b1, 32'h0, 0);

        // Back-to-back with REQ_VALID held high across busy cycles.
        b_we[0] = 1'b1; b_f3[0] = 3'd0; b_addr[0] = 32'h30; b_wdata[0] = 32'h0000_0055;
        b_we[1] = 1'b1; b_f3[1] = 3'd1; b_addr[1] = 32'h32; b_wdata[1] = 32'h0000_6677;
        b_we[2] = 1'b0; b_f3[2] = 3'd2; b_addr[2] = 32'h30; b_wdata[2] = 32'h0;
        idx = 0; nresp = 0; overlap = 0;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) begin
                if (nresp < 3) begin
                    r_rdata[nresp] = resp_rdata;
                    r_err[nresp]   = resp_err;
                end
                nresp++;
                if (req_ready) overlap++;
            end
            if (req_ready) begin
                if (idx < 3) begin
                    req_we = b_we[idx]; req_funct3 = b_f3[idx];
                    req_addr = b_addr[idx]; req_wdata = b_wdata[idx];
                    req_valid = 1'b1;
                    rdy_at[idx] = c;
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b.issued", idx, 3);
        chk("b2b.nresp", nresp, 3);
        chk("b2b.overlap", overlap, 0);
        chk("b2b.gap01", rdy_at[1] - rdy_at[0], 3);
        chk("b2b.gap12", rdy_at[2] - rdy_at[1], 4);
        chk("b2b.rd0", r_rdata[0], 32'h0);
        chk("b2b.rd1", r_rdata[1], 32'h0);
        chk("b2b.rd2", r_rdata[2], 32'h5500_6677);
        chk("b2b.errs", {29'd0, r_err[0], r_err[1], r_err[2]}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
